// File: rtl/pcie_lane_striper.sv
// Stripes MAC bytes round-robin across the active PCIe lanes, one lane-wide
// symbol set per output handshake, with PAD (K23.7) fill on flush.
module pcie_lane_striper #(
    parameter int                         NUM_LANES       = 4,
    parameter int                         MAC_FRAME_WIDTH = 8,
    parameter logic [MAC_FRAME_WIDTH-1:0] PAD_BYTE        = 8'hF7
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [$clog2(NUM_LANES):0]           active_lanes_i,
    input  logic [MAC_FRAME_WIDTH-1:0]           mac_data_frame_i,
    input  logic                                 mac_data_frame_valid_i,
    output logic                                 mac_data_frame_ready_o,
    input  logic                                 flush_i,
    output logic [NUM_LANES*MAC_FRAME_WIDTH-1:0] lane_data_o,
    output logic [NUM_LANES-1:0]                 lane_k_o,
    output logic [NUM_LANES-1:0]                 lane_valid_o,
    input  logic                                 lane_ready_i
);

    localparam int LW = $clog2(NUM_LANES) + 1;
    localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int DW = MAC_FRAME_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FLUSH
    } state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [LW-1:0]           width_q, width_d;
    logic [DW-1:0]           acc_q [NUM_LANES];
    logic [NUM_LANES*DW-1:0] data_q, data_d;
    logic [NUM_LANES-1:0]    k_q, k_d;
    logic [NUM_LANES-1:0]    vld_q, vld_d;

    logic          flush_pend;
    logic          out_full;
    logic          last;
    logic          ready;
    logic          accept;
    logic          pad_load;
    logic [IW-1:0] idx_after;

    // Illegal widths (zero, non-power-of-two, wider than the PHY) fall back to x1.
    function automatic logic lanes_legal(input logic [LW-1:0] a);
        return (a != '0) && ((a & (a - LW'(1))) == '0) && (a <= LW'(NUM_LANES));
    endfunction

    assign flush_pend = (state_q == ST_FLUSH);
    assign out_full   = |vld_q;
    assign last       = (LW'(idx_q) == (width_q - LW'(1)));
    assign ready      = !flush_pend && (!last || !out_full || lane_ready_i);
    assign accept     = mac_data_frame_valid_i && ready;
    assign pad_load   = flush_pend && (!out_full || lane_ready_i);
    assign idx_after  = accept ? (last ? '0 : idx_q + IW'(1)) : idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_after;
        width_d = width_q;
        data_d  = data_q;
        k_d     = k_q;
        vld_d   = vld_q;

        if (state_q == ST_IDLE && !accept) begin
            width_d = lanes_legal(active_lanes_i) ? active_lanes_i : LW'(1);
        end

        // The completing byte bypasses the accumulator straight into its lane.
        if (accept && last) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                k_d[k]   = 1'b0;
                vld_d[k] = (LW'(k) < width_q);
                if (LW'(k) < width_q - LW'(1)) begin
                    data_d[k*DW +: DW] = acc_q[k];
                end else if (LW'(k) == width_q - LW'(1)) begin
                    data_d[k*DW +: DW] = mac_data_frame_i;
                end else begin
                    data_d[k*DW +: DW] = '0;
                end
            end
        end else if (pad_load) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                vld_d[k] = (LW'(k) < width_q);
                if (IW'(k) < idx_q) begin
                    data_d[k*DW +: DW] = acc_q[k];
                    k_d[k]             = 1'b0;
                end else if (LW'(k) < width_q) begin
                    data_d[k*DW +: DW] = PAD_BYTE;
                    k_d[k]             = 1'b1;
                end else begin
                    data_d[k*DW +: DW] = '0;
                    k_d[k]             = 1'b0;
                end
            end
            idx_d = '0;
        end else if (out_full && lane_ready_i) begin
            data_d = '0;
            k_d    = '0;
            vld_d  = '0;
        end

        if (pad_load) begin
            state_d = ST_IDLE;
        end else if (flush_pend || (flush_i && idx_after != '0)) begin
            state_d = ST_FLUSH;
        end else if (idx_after != '0) begin
            state_d = ST_FILL;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            width_q <= LW'(1);
            data_q  <= '0;
            k_q     <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            width_q <= width_d;
            data_q  <= data_d;
            k_q     <= k_d;
            vld_q   <= vld_d;
        end
    end

    // Accumulator is pure data; stale contents are never read once idx_q resets.
    always_ff @(posedge clk_i) begin
        if (accept && !last) begin
            acc_q[idx_q] <= mac_data_frame_i;
        end
    end

    assign mac_data_frame_ready_o = ready;
    assign lane_data_o            = data_q;
    assign lane_k_o               = k_q;
    assign lane_valid_o           = vld_q;

endmodule

// File: tb/tb_pcie_lane_striper.sv
// Scoreboard bench for pcie_lane_striper: a queue-based striping model predicts
// each lane set and the byte-ready handshake; a monitor checks every drained set.
module tb_pcie_lane_striper;

    localparam int NL = 4;
    localparam int DW = 8;
    localparam int LW = $clog2(NL) + 1;
    localparam logic [DW-1:0] PAD = 8'hF7;

    typedef struct {
        logic [NL*DW-1:0] data;
        logic [NL-1:0]    k;
        logic [NL-1:0]    v;
    } set_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [LW-1:0]    active_lanes = '0;
    logic [DW-1:0]    mac_data = '0;
    logic             mac_valid = 1'b0;
    logic             mac_ready;
    logic             flush = 1'b0;
    logic [NL*DW-1:0] lane_data;
    logic [NL-1:0]    lane_k;
    logic [NL-1:0]    lane_valid;
    logic             lane_ready = 1'b0;

    always #5 clk = ~clk;

    pcie_lane_striper #(
        .NUM_LANES(NL),
        .MAC_FRAME_WIDTH(DW),
        .PAD_BYTE(PAD)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .active_lanes_i(active_lanes),
        .mac_data_frame_i(mac_data),
        .mac_data_frame_valid_i(mac_valid),
        .mac_data_frame_ready_o(mac_ready),
        .flush_i(flush),
        .lane_data_o(lane_data),
        .lane_k_o(lane_k),
        .lane_valid_o(lane_valid),
        .lane_ready_i(lane_ready)
    );

    // Reference model: bytes waiting to form a set, current width, flush pending,
    // whether a set is sitting on the lanes, and sets not yet drained.
    logic [DW-1:0] pend[$];
    int            mw = 1;
    bit            mf = 1'b0;
    bit            mo = 1'b0;
    set_t          expq[$];
    bit            last_acc = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input int a);
        return (a >= 1) && (a <= NL) && ((a & (a - 1)) == 0);
    endfunction

    // Lane i carries the i-th collected byte; any lane left over inside the width is PAD.
    function automatic set_t mk_set(input int w);
        set_t s;
        s.data = '0;
        s.k    = '0;
        s.v    = '0;
        for (int i = 0; i < w; i++) begin
            s.v[i] = 1'b1;
            if (i < pend.size()) begin
                s.data[i*DW +: DW] = pend[i];
            end else begin
                s.data[i*DW +: DW] = PAD;
                s.k[i]             = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] d, input bit f, input bit lr);
        bit mready, acc, drain, load, mf_pre;
        int n_pre;
        mac_valid  = v;
        mac_data   = d;
        flush      = f;
        lane_ready = lr;
        #1;
        mready = !mf && ((pend.size() != mw - 1) || !mo || lr);
        chk("ready", mac_ready, mready);
        acc = v && mready;
        @(posedge clk);
        mf_pre = mf;
        n_pre  = pend.size();
        drain  = mo && lr;
        load   = 1'b0;
        if (acc) begin
            pend.push_back(d);
            if (pend.size() == mw) begin
                expq.push_back(mk_set(mw));
                pend.delete();
                load = 1'b1;
            end
        end else if (mf && (!mo || lr)) begin
            expq.push_back(mk_set(mw));
            pend.delete();
            mf   = 1'b0;
            load = 1'b1;
        end
        if (f && !mf_pre && pend.size() != 0) mf = 1'b1;
        if (n_pre == 0 && !mf_pre && !acc) mw = legal(int'(active_lanes)) ? int'(active_lanes) : 1;
        mo = load ? 1'b1 : (drain ? 1'b0 : mo);
        last_acc = acc;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mac_valid = 1'b0;
        flush     = 1'b0;
        #1;
        chk("rst_data", lane_data, 0);
        chk("rst_k", lane_k, 0);
        chk("rst_valid", lane_valid, 0);
        pend.delete();
        expq.delete();
        mf = 1'b0;
        mo = 1'b0;
        mw = 1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: samples on the falling edge, when inputs for the next rising edge are settled.
    bit               hold = 1'b0;
    logic [NL*DW-1:0] hd;
    logic [NL-1:0]    hk, hv;
    initial begin
        set_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("full", |lane_valid, mo);
                if (hold) begin
                    chk("hold_data", lane_data, hd);
                    chk("hold_k", lane_k, hk);
                    chk("hold_valid", lane_valid, hv);
                end
                if (|lane_valid && lane_ready) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_set: got %0h expected none at %0t", lane_data, $time);
                    end else begin
                        e = expq.pop_front();
                        chk("set_data", lane_data, e.data);
                        chk("set_k", lane_k, e.k);
                        chk("set_valid", lane_valid, e.v);
                    end
                end
                hold = |lane_valid && !lane_ready;
                hd   = lane_data;
                hk   = lane_k;
                hv   = lane_valid;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        bit            rv;
        logic [DW-1:0] rd;
        #1;
        chk("rst_data", lane_data, 0);
        chk("rst_k", lane_k, 0);
        chk("rst_valid", lane_valid, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // x4 streaming
        active_lanes = LW'(4);
        idle(1);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        idle(2);

        // backpressure: byte 08 stalls until the held set drains
        for (int i = 1; i <= 7; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        repeat (3) step(1'b1, 8'h08, 1'b0, 1'b0);
        step(1'b1, 8'h08, 1'b0, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);

        // flush of a partial set
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(3);

        // x2, then illegal width 3 behaving as x1
        active_lanes = LW'(2);
        idle(1);
        step(1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b0, 1'b1);
        step(1'b1, 8'h44, 1'b0, 1'b1);
        idle(2);
        active_lanes = LW'(3);
        idle(1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b1);
        idle(2);

        // width change mid-set takes effect only after the set completes
        active_lanes = LW'(4);
        idle(1);
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        active_lanes = LW'(1);
        step(1'b1, 8'h03, 1'b0, 1'b1);
        step(1'b1, 8'h04, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 8'h05, 1'b0, 1'b1);
        idle(2);

        // corners: empty flush, flush with completing byte, reset mid-set
        active_lanes = LW'(4);
        idle(1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(1);
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        step(1'b1, 8'h03, 1'b0, 1'b1);
        step(1'b1, 8'h04, 1'b1, 1'b1);
        idle(2);
        step(1'b1, 8'hC1, 1'b0, 1'b1);
        step(1'b1, 8'hC2, 1'b0, 1'b1);
        do_reset();
        idle(1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b1);
        idle(2);

        // randomized traffic
        rv = 1'b0;
        rd = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!(rv && !last_acc)) begin
                rv = ($urandom_range(0, 3) != 0);
                rd = 8'($urandom);
            end
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) active_lanes = LW'($urandom_range(0, 7));
                else active_lanes = LW'(1 << $urandom_range(0, 2));
            end
            step(rv, rd, ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0));
        end

        // drain everything still in flight
        idle(4);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle(6);
        chk("exp_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcie_lane_striper.md
Name: pcie_lane_striper

Overview:
- Sits between the MAC data-frame interface and the per-lane encode/serialise path inside pcie_phys_top.
- Accepts MAC bytes over a valid/ready handshake and distributes them round-robin across the active lanes: byte n goes to lane n mod W, where W is the link width.
- Emits one lane-wide symbol set per output handshake.
- Supports x1/x2/x4 width selected by link training, plus a flush that pads a partial set with PAD symbols.

Parameters:
NUM_LANES, 4, physical lane count; power of two, at least 1.
MAC_FRAME_WIDTH, 8, bits per MAC byte and per lane symbol.
PAD_BYTE, 8'hF7, data value driven on padded lanes; marked as a K-symbol (PCIe PAD, K23.7).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
active_lanes_i  in  $clog2(NUM_LANES)+1  negotiated link width; legal values are powers of two up to NUM_LANES
mac_data_frame_i  in  MAC_FRAME_WIDTH  MAC byte
mac_data_frame_valid_i  in  1  MAC byte valid
mac_data_frame_ready_o  out  1  striper can accept a byte
flush_i  in  1  single-cycle request to close the current partial set
lane_data_o  out  NUM_LANES*MAC_FRAME_WIDTH  lane k occupies bits [k*W+:W], where W = MAC_FRAME_WIDTH
lane_k_o  out  NUM_LANES  per-lane K-symbol flag (set only on PAD lanes)
lane_valid_o  out  NUM_LANES  per-lane valid; active lanes only
lane_ready_i  in  1  downstream accepts the whole set

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - idx_q=0, width_q=1, flush_pend_q=0.
  - Output register cleared: lane_data_o=0, lane_k_o=0, lane_valid_o=0.
  - mac_data_frame_ready_o=1 once out of reset.
- Width latch:
  - width_q <= active_lanes_i only when idx_q==0, flush_pend_q==0, and no byte is accepted that cycle.
  - An illegal value (0, non-power-of-two, >NUM_LANES) latches 1.
  - A width change mid-set has no effect until that set completes.
- Accumulator: NUM_LANES x MAC_FRAME_WIDTH registers plus idx_q in [0, width_q-1].
- Byte accept (valid & ready):
  - If idx_q < width_q-1: store the byte to acc[idx_q], idx_q++.
  - If idx_q == width_q-1: load the output register with acc[0..width_q-2] plus the incoming byte in lane width_q-1; idx_q <= 0.
  - No extra buffering: the last byte bypasses the accumulator.
- Output register:
  - out_full = |lane_valid_o.
  - On load: lane_valid_o = (1<<width_q)-1 and lane_k_o = 0 (data load) or the pad mask (flush).
  - Lanes >= width_q drive data 0, k 0, valid 0.
  - Cleared on (out_full & lane_ready_i) with no simultaneous load.
  - Load and drain in the same cycle: the new set replaces the old one, with no bubble.
- Output latency: the set appears on lane_* one cycle after the last byte is accepted. Data and valid are stable while out_full & !lane_ready_i.
- Ready, combinational from lane_ready_i; the path is permitted:
  - ready_o = !flush_pend_q & ((idx_q != width_q-1) | !out_full | lane_ready_i).
  - With lane_ready_i held at 1, throughput is one byte per cycle.
- Flush:
  - flush_i sets flush_pend_q if, after any same-cycle byte accept, idx_q != 0. Otherwise flush_i is ignored (empty, or that byte completed the set).
  - A byte accepted in the same cycle as flush_i is included before padding.
  - While flush_pend_q is set and (!out_full | lane_ready_i): load lanes 0..idx_q-1 from the accumulator and lanes idx_q..width_q-1 with PAD_BYTE, lane_k_o=1 on those lanes.
  - Same cycle: idx_q <= 0, flush_pend_q <= 0.
  - flush_i while flush_pend_q is already set is absorbed.
- FSM (derived): IDLE (idx 0) -> FILL (idx>0) -> IDLE on set complete; FILL -> FLUSH (flush_pend_q) -> IDLE on pad load.
- Reset mid-set or mid-flush discards all partial data; no set is emitted.

Test Plan:
1. Width x4, lane_ready_i=1, bytes 01..08 back-to-back:
   - Expected: lane_data_o=32'h04030201, then 32'h08070605, one cycle after bytes 04 and 08 respectively.
   - lane_valid_o=4'hF, lane_k_o=0; ready never drops.
2. Width x4, lane_ready_i=0, bytes 01..08:
   - First set is held stable.
   - Ready drops while idx_q=3 with out_full, so byte 08 stalls.
   - Raise lane_ready_i: 08 is accepted the same cycle and the second set follows with no bubble.
3. Width x4, bytes AA, BB, then flush_i:
   - lane_data_o=32'hF7F7BBAA, lane_k_o=4'b1100, lane_valid_o=4'hF.
   - Ready is low for exactly the flush-pending cycle(s).
4. active_lanes_i=2, bytes 11, 22, 33, 44:
   - Sets 16'h2211 then 16'h4433 in lanes 0-1, lane_valid_o=4'b0011, lanes 2-3 data 0.
   - Repeat with active_lanes_i=3: behaves as x1.
5. Width x4, bytes 01, 02 accumulated, then active_lanes_i->1, then bytes 03, 04:
   - Set 32'h04030201 is emitted at x4.
   - Next byte 05 is emitted alone as lane 0, lane_valid_o=4'b0001.
6. Corner cases:
   - Flush with idx_q=0: no output.
   - Flush with the completing byte 04 in the same cycle: exactly one set, no pad.
   - rst_ni pulsed low with 2 bytes pending: all outputs 0 immediately; the next 4 bytes form a clean set.
